// File: rtl/rca_pkg.sv
// Shared constants and the width legality check for the ripple-carry adder.
package rca_pkg;

  localparam int unsigned RCA_DEFAULT_WIDTH = 4;
  localparam int unsigned RCA_MAX_WIDTH     = 32;

  function automatic bit rca_width_ok(input int unsigned w);
    return (w >= 1) && (w <= RCA_MAX_WIDTH);
  endfunction

endpackage

// File: rtl/rca_full_adder.sv
// Single-bit full adder; one stage of the ripple chain.
module rca_full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic p;

  assign p    = a ^ b;
  assign s    = p ^ cin;
  assign cout = (a & b) | (cin & p);

endmodule

// File: rtl/rca.sv
// Registered ripple-carry adder: {cout,sum} <= a + b + ci, one cycle latency.
// Define RCA_OVF_EN to add the registered signed-overflow output ovf.
module rca
  import rca_pkg::*;
#(
  parameter int unsigned WIDTH = RCA_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic             out_valid,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef RCA_OVF_EN
  ,
  output logic             ovf
`endif
);

  if (!rca_width_ok(WIDTH)) begin : g_bad_width
    $error("rca: WIDTH out of range 1..32");
  end

  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] s;

  assign c[0] = ci;

  // Carry ripples LSB to MSB through the full-adder chain.
  for (genvar i = 0; i < int'(WIDTH); i++) begin : g_fa
    rca_full_adder u_fa (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (c[i]),
      .s    (s[i]),
      .cout (c[i+1])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sum       <= '0;
      cout      <= 1'b0;
      out_valid <= 1'b0;
    end else if (in_valid) begin
      sum       <= s;
      cout      <= c[WIDTH];
      out_valid <= 1'b1;
    end else begin
      out_valid <= 1'b0;
    end
  end

`ifdef RCA_OVF_EN
  // Signed overflow: carry into the sign bit differs from carry out of it.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf <= 1'b0;
    end else if (in_valid) begin
      ovf <= c[WIDTH] ^ c[WIDTH-1];
    end
  end
`endif

endmodule

// File: tb/tb_rca.sv
// Self-checking bench for rca at WIDTH=4, 1 and 16 against an arithmetic model.
module tb_rca;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        ci = 1'b0;

  logic        v4, v1, v16;
  logic [3:0]  s4;
  logic [0:0]  s1;
  logic [15:0] s16;
  logic        c4, c1, c16;
`ifdef RCA_OVF_EN
  logic        o4, o1, o16;
`endif

  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  rca #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a[3:0]), .b(b[3:0]), .ci(ci),
    .out_valid(v4), .sum(s4), .cout(c4)
`ifdef RCA_OVF_EN
    , .ovf(o4)
`endif
  );

  rca #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a[0:0]), .b(b[0:0]), .ci(ci),
    .out_valid(v1), .sum(s1), .cout(c1)
`ifdef RCA_OVF_EN
    , .ovf(o1)
`endif
  );

  rca #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b), .ci(ci),
    .out_valid(v16), .sum(s16), .cout(c16)
`ifdef RCA_OVF_EN
    , .ovf(o16)
`endif
  );

  // Unsigned total of w-bit operands plus carry-in.
  function automatic longint add_u(input int w, input longint x, input longint y, input bit c);
    longint m;
    m = (longint'(1) << w) - 1;
    return (x & m) + (y & m) + longint'(c);
  endfunction

  function automatic longint sval(input int w, input longint x);
    longint m;
    m = (longint'(1) << w) - 1;
    x = x & m;
    return x[w-1] ? x - (longint'(1) << w) : x;
  endfunction

  // Signed overflow: true signed total falls outside the w-bit range.
  function automatic bit ovf_s(input int w, input longint x, input longint y, input bit c);
    longint t;
    t = sval(w, x) + sval(w, y) + longint'(c);
    return (t > (longint'(1) << (w - 1)) - 1) || (t < -(longint'(1) << (w - 1)));
  endfunction

  // Expected register contents.
  logic        e_vld = 1'b0;
  longint      e_t4 = 0, e_t1 = 0, e_t16 = 0;
  bit          e_o4 = 1'b0, e_o1 = 1'b0, e_o16 = 1'b0;

  always @(posedge clk) begin
    chk_en <= 1'b1;
    if (rst) begin
      e_vld <= 1'b0;
      e_t4  <= 0; e_t1 <= 0; e_t16 <= 0;
      e_o4  <= 1'b0; e_o1 <= 1'b0; e_o16 <= 1'b0;
    end else if (in_valid) begin
      e_vld <= 1'b1;
      e_t4  <= add_u(4, longint'(a), longint'(b), ci);
      e_t1  <= add_u(1, longint'(a), longint'(b), ci);
      e_t16 <= add_u(16, longint'(a), longint'(b), ci);
      e_o4  <= ovf_s(4, longint'(a), longint'(b), ci);
      e_o1  <= ovf_s(1, longint'(a), longint'(b), ci);
      e_o16 <= ovf_s(16, longint'(a), longint'(b), ci);
    end else begin
      e_vld <= 1'b0;
    end
  end

  task automatic cmp(input string name, input longint got, input longint exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Continuous comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      cmp("v4", longint'(v4), longint'(e_vld));
      cmp("sum_cout4", longint'({c4, s4}), e_t4);
      cmp("v1", longint'(v1), longint'(e_vld));
      cmp("sum_cout1", longint'({c1, s1}), e_t1);
      cmp("v16", longint'(v16), longint'(e_vld));
      cmp("sum_cout16", longint'({c16, s16}), e_t16);
`ifdef RCA_OVF_EN
      cmp("ovf4", longint'(o4), longint'(e_o4));
      cmp("ovf1", longint'(o1), longint'(e_o1));
      cmp("ovf16", longint'(o16), longint'(e_o16));
`endif
    end
  end

  task automatic step(input bit r, input bit v, input logic [15:0] av, input logic [15:0] bv, input bit cv);
    rst = r; in_valid = v; a = av; b = bv; ci = cv;
    @(posedge clk);
    #1;
  endtask

  // Hand-computed literals on the 4-bit instance.
  task automatic lit4(input string name, input bit ev, input int es, input bit ec);
    cmp({name, "_vld"}, longint'(v4), longint'(ev));
    cmp({name, "_sum"}, longint'(s4), longint'(es));
    cmp({name, "_cout"}, longint'(c4), longint'(ec));
  endtask

  int sweep_exp [8] = '{1, 1, 2, 2, 3, 3, 4, 4};

  initial begin
    logic [8:0] k;
    // Reset held with valid input present.
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b1, 16'd9, 16'd9, 1'b1);
      lit4("reset", 1'b0, 0, 1'b0);
`ifdef RCA_OVF_EN
      cmp("reset_ovf", longint'(o4), 0);
`endif
    end
    // Small sweep {a,b,ci} = 1..8.
    for (int i = 1; i <= 8; i++) begin
      k = 9'(i);
      step(1'b0, 1'b1, 16'(k[8:5]), 16'(k[4:1]), k[0]);
      lit4("sweep", 1'b1, sweep_exp[i-1], 1'b0);
    end
    // Carry boundaries.
    step(1'b0, 1'b1, 16'd15, 16'd15, 1'b1);
    lit4("max", 1'b1, 15, 1'b1);
    step(1'b0, 1'b1, 16'd15, 16'd0, 1'b1);
    lit4("ripple", 1'b1, 0, 1'b1);
    step(1'b0, 1'b1, 16'd0, 16'd0, 1'b0);
    lit4("zero", 1'b1, 0, 1'b0);
    step(1'b0, 1'b1, 16'd8, 16'd8, 1'b0);
    lit4("neg_ovf", 1'b1, 0, 1'b1);
`ifdef RCA_OVF_EN
    cmp("neg_ovf_ovf", longint'(o4), 1);
`endif
    // Hold when in_valid drops.
    step(1'b0, 1'b1, 16'd3, 16'd4, 1'b0);
    lit4("cap7", 1'b1, 7, 1'b0);
    step(1'b0, 1'b0, 16'd9, 16'd2, 1'b1);
    lit4("hold", 1'b0, 7, 1'b0);
    step(1'b0, 1'b0, 16'd12, 16'd1, 1'b0);
    lit4("hold2", 1'b0, 7, 1'b0);
    // Reset beats in_valid, then same stimulus after release.
    step(1'b1, 1'b1, 16'd5, 16'd6, 1'b0);
    lit4("midrst", 1'b0, 0, 1'b0);
    step(1'b0, 1'b1, 16'd5, 16'd6, 1'b0);
    lit4("after_rst", 1'b1, 11, 1'b0);
    // Exhaustive 4-bit operands (model checks all three widths).
    for (int i = 0; i < 512; i++) begin
      k = 9'(i);
      step(1'b0, 1'b1, 16'(k[8:5]), 16'(k[4:1]), k[0]);
    end
    // Random full-width traffic with gaps and occasional reset.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0),
           16'($urandom), 16'($urandom), 1'($urandom));
    end
    // Directed 16-bit extremes.
    step(1'b0, 1'b1, 16'hffff, 16'hffff, 1'b1);
    step(1'b0, 1'b1, 16'hffff, 16'h0000, 1'b1);
    step(1'b0, 1'b1, 16'h7fff, 16'h0000, 1'b1);
    step(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
    step(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/rca.md
Name: rca

Overview:
- Parameterised ripple-carry adder: computes a + b + ci as a chain of single-bit full adders, with carry rippling from bit 0 to the MSB.
- The sum and carry-out are captured in output registers, giving one cycle of latency.
- Used as the generic small-width adder primitive in datapaths that do not need carry-lookahead speed.
- Default configuration is 4 bits.

Parameters:
- WIDTH, 4, operand and sum width in bits; legal range 1..32.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- in_valid  input  1  qualifies a, b, ci for capture this cycle
- a  input  WIDTH  operand A, unsigned
- b  input  WIDTH  operand B, unsigned
- ci  input  1  carry-in to bit 0
- out_valid  output  1  sum and cout hold a freshly computed result
- sum  output  WIDTH  registered sum bits [WIDTH-1:0]
- cout  output  1  registered carry out of the MSB
- ovf  output  1  registered signed overflow; present only with RCA_OVF_EN

Behaviour:
- Combinational core:
  - c[0] = ci.
  - For i in 0..WIDTH-1: s[i] = a[i]^b[i]^c[i], and c[i+1] = (a[i]&b[i]) | (c[i]&(a[i]^b[i])).
  - The combined result {c[WIDTH], s} equals a + b + ci, exactly WIDTH+1 bits; there is no truncation beyond cout.
- Registers on rising clk:
  - If rst=1: sum<=0, cout<=0, out_valid<=0, ovf<=0. Reset has priority over in_valid.
  - Else if in_valid=1: sum<=s, cout<=c[WIDTH], out_valid<=1.
  - Else: sum and cout hold their previous values, and out_valid<=0.
- Latency: exactly 1 cycle from in_valid to out_valid.
  - Throughput: one result per cycle.
  - There is no backpressure.
- Outputs change only on clock edges; there are no combinational paths from inputs to outputs.
- Boundary cases:
  - Max operands, a=b=2^WIDTH-1 with ci=1: sum = all ones, cout=1.
  - Zero operands with ci=0: sum=0, cout=0.
  - ci alone propagates through an all-ones a with b=0: sum=0, cout=1. This is the full ripple path and sets the critical timing.
  - Reset asserted in the same cycle as in_valid: the input is dropped, and outputs are 0 on the next cycle.
  - Reset deasserted: the first result appears one cycle after the first in_valid.
- X-handling: none required. Inputs are assumed 2-state whenever in_valid=1.

Optional Feature:
- Macro: RCA_OVF_EN.
- When defined:
  - Port ovf exists.
  - On capture, ovf <= c[WIDTH] ^ c[WIDTH-1], i.e. two's-complement signed overflow of a + b + ci.
  - ovf is reset to 0 and holds its value when in_valid=0.
  - For WIDTH=1, ovf <= c[1] ^ ci.
- When undefined:
  - The ovf port and its register are absent.
  - All other behaviour is identical.

Decomposition:
- Package rca_pkg holds:
  - localparam RCA_DEFAULT_WIDTH = 4.
  - localparam RCA_MAX_WIDTH = 32.
  - A function or assertion helper that checks WIDTH is in range.
- Sub-module rca_full_adder (inputs a, b, cin; outputs s, cout) is purely combinational.
  - rca instantiates it WIDTH times in a generate loop, chaining the carries.
  - No behavioural "+" operator is allowed in the core.

Test Plan:
- Reset: rst=1 for 2 cycles with in_valid=1, a=9, b=9, ci=1 -> sum=0, cout=0, out_valid=0 throughout, and ovf=0 if enabled.
- Small sweep, one value per cycle with in_valid=1: {a,b,ci} = 1..8 (WIDTH=4). Each result appears one cycle later:
  - 1 -> a=0 b=0 ci=1: sum=1, cout=0
  - 3 -> a=0 b=1 ci=1: sum=2, cout=0
  - 7 -> a=0 b=3 ci=1: sum=4, cout=0
  - 8 -> a=0 b=4 ci=0: sum=4, cout=0
- Carry boundaries:
  - a=15 b=15 ci=1 -> sum=15, cout=1.
  - a=15 b=0 ci=1 -> sum=0, cout=1 (full ripple).
  - a=8 b=8 ci=0 -> sum=0, cout=1, ovf=1 if enabled.
- Hold/valid: after a=3 b=4 ci=0 captured (sum=7), drive in_valid=0 and change a and b -> sum stays 7, out_valid=0.
- Mid-stream reset: a=5 b=6 ci=0 with in_valid=1 and rst=1 in the same cycle -> next cycle sum=0, out_valid=0. Then release rst and apply the same stimulus -> sum=11, cout=0.
- Exhaustive check at WIDTH=4: all 512 {a,b,ci} combinations; compare {cout,sum} against a+b+ci one cycle later. Repeat with random samples at WIDTH=1 and WIDTH=16.
